// File: rtl/load_store_unit.sv
// Load/store unit: runs one aligned 8-byte bus transaction per request, then lane-aligns and extends the load data.
// Build option: define LSU_MISALIGN_CHECK_EN to trap non-naturally-aligned accesses without touching the bus.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_Enable,
  input  logic [3:0]  MEM_Ctrl,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic        ALU_MEM_Finish,
  output logic [63:0] mem_rdata,
  output logic        mem_misalign,
  output logic        mem_fault,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_resp_valid,
  input  logic [63:0] bus_rdata,
  input  logic        bus_resp_err
);

  // state | meaning
  // IDLE  | waiting for MEM_Enable
  // REQ   | bus request presented, waiting for ready
  // RESP  | request accepted, waiting for response
  // DONE  | one-cycle finish pulse
  // HOLD  | waiting for MEM_Enable to drop before re-arming
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_DONE, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_ctrl;
  logic [2:0]  r_off;
  logic [2:0]  w_off;
  logic [7:0]  w_size_mask;
  logic [7:0]  w_wstrb;
  logic [63:0] w_wdata;
  logic        w_misalign;
  logic        w_accept;
  logic [63:0] w_rshift;
  logic [63:0] w_load;

  assign w_off    = mem_addr[2:0];
  assign w_accept = (r_state == S_IDLE) && MEM_Enable;

  always_comb begin
    w_size_mask = 8'h01;
    case (MEM_Ctrl[1:0])
      2'b00: w_size_mask = 8'h01;
      2'b01: w_size_mask = 8'h03;
      2'b10: w_size_mask = 8'h0F;
      2'b11: w_size_mask = 8'hFF;
      default: w_size_mask = 8'h01;
    endcase
  end

  // Bits pushed past lane 7 fall off the top of the 8-bit / 64-bit results.
  assign w_wstrb = w_size_mask << w_off;
  assign w_wdata = mem_wdata << {w_off, 3'b000};

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    w_misalign = 1'b0;
    case (MEM_Ctrl[1:0])
      2'b00: w_misalign = 1'b0;
      2'b01: w_misalign = w_off[0];
      2'b10: w_misalign = |w_off[1:0];
      2'b11: w_misalign = |w_off;
      default: w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_rshift = bus_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load = 64'd0;
    case (r_ctrl[1:0])
      2'b00: w_load = r_ctrl[2] ? {56'd0, w_rshift[7:0]}  : {{56{w_rshift[7]}}, w_rshift[7:0]};
      2'b01: w_load = r_ctrl[2] ? {48'd0, w_rshift[15:0]} : {{48{w_rshift[15]}}, w_rshift[15:0]};
      2'b10: w_load = r_ctrl[2] ? {32'd0, w_rshift[31:0]} : {{32{w_rshift[31]}}, w_rshift[31:0]};
      2'b11: w_load = w_rshift;
      default: w_load = 64'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    bus_req_valid  = 1'b0;
    ALU_MEM_Finish = 1'b0;
    case (r_state)
      S_IDLE: if (MEM_Enable) w_next = w_misalign ? S_DONE : S_REQ;
      S_REQ: begin
        bus_req_valid = 1'b1;
        if (bus_req_ready) w_next = S_RESP;
      end
      S_RESP: if (bus_resp_valid) w_next = S_DONE;
      S_DONE: begin
        ALU_MEM_Finish = 1'b1;
        w_next = MEM_Enable ? S_HOLD : S_IDLE;
      end
      S_HOLD: if (!MEM_Enable) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl       <= 4'd0;
      r_off        <= 3'd0;
      bus_addr     <= 64'd0;
      bus_we       <= 1'b0;
      bus_wstrb    <= 8'd0;
      bus_wdata    <= 64'd0;
      mem_misalign <= 1'b0;
      mem_fault    <= 1'b0;
      mem_rdata    <= 64'd0;
    end else if (w_accept) begin
      r_ctrl       <= MEM_Ctrl;
      r_off        <= w_off;
      bus_addr     <= {mem_addr[63:3], 3'b000};
      bus_we       <= MEM_Ctrl[3];
      bus_wstrb    <= MEM_Ctrl[3] ? w_wstrb : 8'd0;
      bus_wdata    <= MEM_Ctrl[3] ? w_wdata : 64'd0;
      mem_misalign <= w_misalign;
      mem_fault    <= 1'b0;
    end else if (r_state == S_RESP && bus_resp_valid) begin
      mem_fault <= bus_resp_err;
      // Stores and faulted loads leave the previous load result in place.
      if (!r_ctrl[3] && !bus_resp_err) mem_rdata <= w_load;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed and random accesses against a byte-level reference model.
// Honours LSU_MISALIGN_CHECK_EN the same way the design does.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_Enable = 1'b0;
  logic [3:0]  MEM_Ctrl = 4'd0;
  logic [63:0] mem_addr = 64'd0;
  logic [63:0] mem_wdata = 64'd0;
  logic        ALU_MEM_Finish;
  logic [63:0] mem_rdata;
  logic        mem_misalign;
  logic        mem_fault;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_resp_valid = 1'b0;
  logic [63:0] bus_rdata = 64'd0;
  logic        bus_resp_err = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_rdata = 64'd0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .MEM_Enable(MEM_Enable), .MEM_Ctrl(MEM_Ctrl),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ALU_MEM_Finish(ALU_MEM_Finish),
    .mem_rdata(mem_rdata), .mem_misalign(mem_misalign), .mem_fault(mem_fault),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata), .bus_resp_err(bus_resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(input logic [63:0] word, input int off, input int sz, input bit uns);
    logic [63:0] v;
    int n;
    v = 64'd0;
    n = 1 << sz;
    for (int b = 0; b < n; b++)
      if (off + b < 8) v[b*8 +: 8] = word[(off+b)*8 +: 8];
    if (!uns && n < 8 && v[n*8-1])
      for (int i = n*8; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] ref_strb(input int off, input int sz);
    logic [7:0] s;
    s = 8'd0;
    for (int b = 0; b < (1 << sz); b++)
      if (off + b < 8) s[off+b] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] wd, input int off);
    logic [63:0] r;
    r = 64'd0;
    for (int b = 0; b < 8; b++)
      if (off + b < 8) r[(off+b)*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic bit ref_misalign(input int off, input int sz);
`ifdef LSU_MISALIGN_CHECK_EN
    return (off % (1 << sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // One complete request with configurable ready/response stalls; checks fields, latency and results.
  task automatic run_txn(input string tag, input logic [3:0] ctrl, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata, input bit err,
                         input int req_stall, input int resp_stall);
    int off, sz, k, fin_k, req_cycles, phase, waitc, exp_lat;
    bit st, mis, fin_mis, fin_fault;
    logic [63:0] fin_rdata;
    off = int'(addr[2:0]);
    sz = int'(ctrl[1:0]);
    st = ctrl[3];
    mis = ref_misalign(off, sz);
    k = 0; fin_k = -1; req_cycles = 0; phase = 0; waitc = 0;
    fin_mis = 1'b0; fin_fault = 1'b0; fin_rdata = 64'd0;
    @(negedge clk);
    MEM_Enable = 1'b1; MEM_Ctrl = ctrl; mem_addr = addr; mem_wdata = wdata;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    while (fin_k < 0 && k < 60) begin
      @(negedge clk);
      k++;
      if (bus_req_valid) begin
        req_cycles++;
        if (req_cycles == 1 || waitc == req_stall) begin
          check({tag, " bus_addr"}, bus_addr, {addr[63:3], 3'b000});
          check({tag, " bus_we"}, 64'(bus_we), 64'(st));
          check({tag, " bus_wstrb"}, 64'(bus_wstrb), st ? 64'(ref_strb(off, sz)) : 64'd0);
          if (st) check({tag, " bus_wdata"}, bus_wdata, ref_wdata(wdata, off));
        end
      end
      if (ALU_MEM_Finish) begin
        fin_k = k; fin_mis = mem_misalign; fin_fault = mem_fault; fin_rdata = mem_rdata;
      end
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
      case (phase)
        0: if (bus_req_valid) begin
             if (waitc == req_stall) begin
               bus_req_ready = 1'b1; phase = 1; waitc = 0;
             end else begin
               waitc++;
               bus_resp_valid = 1'b1; bus_resp_err = 1'b1; bus_rdata = {$urandom, $urandom};
             end
           end
        1: if (waitc == resp_stall) begin
             bus_resp_valid = 1'b1; bus_rdata = rdata; bus_resp_err = err; phase = 2;
           end else waitc++;
        default: ;
      endcase
    end
    MEM_Enable = 1'b0;
    exp_lat = mis ? 1 : 3 + req_stall + resp_stall;
    if (!mis && !st && !err) exp_rdata = ref_load(rdata, off, sz, ctrl[2]);
    check({tag, " finish_latency"}, 64'(fin_k), 64'(exp_lat));
    check({tag, " req_cycles"}, 64'(req_cycles), mis ? 64'd0 : 64'(req_stall + 1));
    check({tag, " misalign"}, 64'(fin_mis), 64'(mis));
    check({tag, " fault"}, 64'(fin_fault), 64'(!mis && err));
    check({tag, " mem_rdata"}, fin_rdata, exp_rdata);
    @(negedge clk);
    check({tag, " finish_pulse_width"}, 64'(ALU_MEM_Finish), 64'd0);
  endtask

  initial begin
    int vcount, fcount, hphase;
    logic [63:0] hword;
    logic [63:0] rw, ra;
    logic [3:0] rc;

    @(negedge clk);
    check("reset ctl_outputs", 64'({ALU_MEM_Finish, mem_misalign, mem_fault, bus_req_valid, bus_we, bus_wstrb}), 64'd0);
    check("reset mem_rdata", mem_rdata, 64'd0);
    check("reset bus_addr", bus_addr, 64'd0);
    check("reset bus_wdata", bus_wdata, 64'd0);
    rst = 1'b0;

    run_txn("lb", 4'b0000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 1'b0, 0, 0);
    check("lb value", mem_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    run_txn("lwu", 4'b0110, 64'h8000_0004, 64'd0, 64'hDEAD_BEEF_0000_0000, 1'b0, 2, 0);
    check("lwu value", mem_rdata, 64'h0000_0000_DEAD_BEEF);
    run_txn("sh", 4'b1001, 64'h8000_0006, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 1);
    check("sh wstrb", 64'(bus_wstrb), 64'hC0);
    check("sh wdata", bus_wdata, 64'h1234_0000_0000_0000);
    run_txn("lw_mis", 4'b0010, 64'h8000_0002, 64'd0, 64'h0102_0304_0506_0708, 1'b0, 0, 0);
    run_txn("ld_err", 4'b0011, 64'h8000_0010, 64'd0, 64'h5555_5555_5555_5555, 1'b1, 1, 1);

    // Level-held request for 10 cycles must produce a single transaction.
    hword = 64'h0123_4567_89AB_CDEF;
    vcount = 0; fcount = 0; hphase = 0;
    @(negedge clk);
    MEM_Enable = 1'b1; MEM_Ctrl = 4'b0011; mem_addr = 64'h8000_0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_req_valid) vcount++;
      if (ALU_MEM_Finish) fcount++;
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
      if (hphase == 0 && bus_req_valid) begin bus_req_ready = 1'b1; hphase = 1; end
      else if (hphase == 1) begin bus_resp_valid = 1'b1; bus_rdata = hword; bus_resp_err = 1'b0; hphase = 2; end
    end
    exp_rdata = hword;
    check("hold req_cycles", 64'(vcount), 64'd1);
    check("hold finish_count", 64'(fcount), 64'd1);
    check("hold mem_rdata", mem_rdata, exp_rdata);
    MEM_Enable = 1'b0;
    run_txn("rearm", 4'b0101, 64'h8000_0102, 64'd0, 64'h0000_0000_F00D_0000, 1'b0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = {$urandom, $urandom};
      rw = {$urandom, $urandom};
      run_txn($sformatf("rnd%0d", i), rc, ra, rw, {$urandom, $urandom},
              $urandom_range(0, 7) == 0, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    // Reset while the request is on the bus.
    @(negedge clk);
    MEM_Enable = 1'b1; MEM_Ctrl = 4'b1011; mem_addr = 64'h8000_0200; mem_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    check("rst_mid valid_before", 64'(bus_req_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid bus_req_valid", 64'(bus_req_valid), 64'd0);
    check("rst_mid ctl_outputs", 64'({ALU_MEM_Finish, mem_misalign, mem_fault, bus_we, bus_wstrb}), 64'd0);
    check("rst_mid mem_rdata", mem_rdata, 64'd0);
    check("rst_mid bus_addr", bus_addr, 64'd0);
    check("rst_mid bus_wdata", bus_wdata, 64'd0);
    exp_rdata = 64'd0;
    MEM_Enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus_resp_valid = 1'b1; bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF; bus_resp_err = 1'b1;
    @(negedge clk);
    bus_resp_valid = 1'b0;
    check("idle_resp finish", 64'(ALU_MEM_Finish), 64'd0);
    check("idle_resp fault", 64'(mem_fault), 64'd0);
    run_txn("post_rst", 4'b0001, 64'h8000_0300, 64'd0, 64'h0000_0000_0000_8001, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
